// File: rtl/vproc_uop_seq.sv
// ---------------------------------------------------------------------------
// vproc_uop_seq
// Splits one vector operation into a sequence of micro-ops. Each micro-op
// covers OP_W bits of one vector register. A register group of 2^emul
// registers is walked chunk by chunk until the operation's total byte count
// is covered.
//
// Encodings
//   op_vsew_i : 0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = invalid (never sent)
//   op_emul_i : 0/1/2/3 = group of 1/2/4/8 registers
//   op_evl_i  : 0 = DEFAULT  (vl << vsew bytes)
//               1 = EVL_1    (one element)
//               2 = EVL_MASK (ceil(vl/8) bytes, mask layout)
//               3 = EVL_MAX  (whole register group)
//
// Ports
//   clk_i, async_rst_ni      clock, asynchronous active-low reset
//   op_valid_i / op_ready_o  operation handshake (ready only while idle)
//   op_vsew_i, op_emul_i,
//   op_evl_i, op_vl_i        operation shape
//   op_vd_i, op_vs2_i        base register addresses of the group
//   uop_valid_o/uop_ready_i  micro-op handshake
//   uop_vd_o, uop_vs2_o      register addressed by the current micro-op
//   uop_bytes_o              chunk offset within that register
//   uop_be_o                 per-byte enable of the current chunk
//   uop_first_o/uop_last_o   first / last micro-op of the operation
//   err_o                    one-cycle pulse for a misaligned operation
//   flush_i                  aborts the current operation, blocks new ones
// ---------------------------------------------------------------------------
module vproc_uop_seq #(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned OP_W   = 32
) (
    input  logic                          clk_i,
    input  logic                          async_rst_ni,
    input  logic                          op_valid_i,
    output logic                          op_ready_o,
    input  logic [1:0]                    op_vsew_i,
    input  logic [1:0]                    op_emul_i,
    input  logic [1:0]                    op_evl_i,
    input  logic [$clog2(VREG_W):0]       op_vl_i,
    input  logic [4:0]                    op_vd_i,
    input  logic [4:0]                    op_vs2_i,
    output logic                          uop_valid_o,
    input  logic                          uop_ready_i,
    output logic [4:0]                    uop_vd_o,
    output logic [4:0]                    uop_vs2_o,
    output logic [((VREG_W > OP_W) ? $clog2(VREG_W/OP_W) : 1)-1:0] uop_bytes_o,
    output logic [OP_W/8-1:0]             uop_be_o,
    output logic                          uop_first_o,
    output logic                          uop_last_o,
    output logic                          err_o,
    input  logic                          flush_i
);

    localparam int unsigned OPB      = OP_W / 8;
    localparam int unsigned OPB_LOG2 = $clog2(OPB);
    localparam int unsigned C_LOG2   = $clog2(VREG_W / OP_W);
    localparam int unsigned BYTES_W  = (C_LOG2 > 0) ? C_LOG2 : 1;
    localparam int unsigned VL_W     = $clog2(VREG_W) + 1;
    // Wide enough for vl shifted by the largest element width and for a
    // full eight-register group.
    localparam int unsigned TB_W     = VL_W + 3;
    localparam int unsigned OFF_W    = TB_W + OPB_LOG2;

    localparam logic [1:0] EVL_DEFAULT = 2'd0;
    localparam logic [1:0] EVL_1       = 2'd1;
    localparam logic [1:0] EVL_MASK    = 2'd2;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_RUN  = 1'b1;

    logic            r_state;
    logic [4:0]      r_vd;
    logic [4:0]      r_vs2;
    logic [TB_W-1:0] r_tb;
    logic [TB_W-1:0] r_c;
    logic            r_err;

    logic [TB_W-1:0]  w_tb;
    logic [4:0]       w_grp_mask;
    logic             w_misalign;
    logic             w_run;
    logic             w_op_fire;
    logic             w_uop_fire;
    logic [OFF_W-1:0] w_off;
    logic [OFF_W-1:0] w_rem;
    logic             w_last;
    logic [OPB-1:0]   w_be;

    // Total byte count of the offered operation under its length policy.
    always_comb begin
        w_tb = '0;
        case (op_evl_i)
            EVL_DEFAULT: w_tb = TB_W'(op_vl_i) << op_vsew_i;
            EVL_1:       w_tb = TB_W'(1) << op_vsew_i;
            EVL_MASK:    w_tb = (TB_W'(op_vl_i) + TB_W'(7)) >> 3;
            default:     w_tb = TB_W'(VREG_W / 8) << op_emul_i;
        endcase
    end

    // Both base registers must sit on a group boundary.
    assign w_grp_mask = (5'd1 << op_emul_i) - 5'd1;
    assign w_misalign = |((op_vd_i | op_vs2_i) & w_grp_mask);

    // Flush masks ready so that an op offered while flushing never transfers.
    assign w_run      = (r_state == S_RUN);
    assign op_ready_o = !w_run && !flush_i;
    assign w_op_fire  = op_valid_i && op_ready_o;
    assign w_uop_fire = w_run && uop_ready_i && !flush_i;

    // Bytes still to cover from the current chunk onward; in RUN this is
    // always non-zero because the last chunk returns the block to IDLE.
    assign w_off  = OFF_W'(r_c) << OPB_LOG2;
    assign w_rem  = OFF_W'(r_tb) - w_off;
    assign w_last = (w_rem <= OFF_W'(OPB));

    always_comb begin
        w_be = '0;
        for (int b = 0; b < int'(OPB); b++) begin
            w_be[b] = (OFF_W'(b) < w_rem);
        end
    end

    // Outputs are forced to zero whenever no micro-op is being presented.
    assign uop_valid_o = w_run;
    assign uop_vd_o    = w_run ? r_vd  + 5'(r_c >> C_LOG2) : '0;
    assign uop_vs2_o   = w_run ? r_vs2 + 5'(r_c >> C_LOG2) : '0;
    assign uop_bytes_o = w_run ? BYTES_W'(r_c & TB_W'((1 << C_LOG2) - 1)) : '0;
    assign uop_be_o    = w_run ? w_be : '0;
    assign uop_first_o = w_run && (r_c == '0);
    assign uop_last_o  = w_run && w_last;
    assign err_o       = r_err;

    // Sequencer state. Flush outranks both handshakes; an accepted op that
    // is misaligned or empty is consumed without leaving IDLE.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            r_state <= S_IDLE;
            r_vd    <= '0;
            r_vs2   <= '0;
            r_tb    <= '0;
            r_c     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_op_fire && w_misalign;
            if (flush_i) begin
                r_state <= S_IDLE;
            end else if (w_op_fire) begin
                r_vd  <= op_vd_i;
                r_vs2 <= op_vs2_i;
                r_tb  <= w_tb;
                r_c   <= '0;
                if (!w_misalign && (w_tb != '0)) begin
                    r_state <= S_RUN;
                end
            end else if (w_uop_fire) begin
                if (w_last) begin
                    r_state <= S_IDLE;
                end else begin
                    r_c <= r_c + TB_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_vproc_uop_seq.sv
// ---------------------------------------------------------------------------
// tb_vproc_uop_seq
// Self-checking bench for vproc_uop_seq with VREG_W=128, OP_W=32.
// A table of hand-derived operations is run first, followed by stall,
// flush and reset sequences, then randomized operations checked against a
// behavioural model that expands an operation into its list of micro-ops.
// ---------------------------------------------------------------------------
module tb_vproc_uop_seq;

    localparam int OPB      = 4;
    localparam int CHUNKS   = 4;
    localparam int REG_B    = 16;

    typedef struct {
        logic [1:0] vsew;
        logic [1:0] emul;
        logic [1:0] evl;
        logic [7:0] vl;
        logic [4:0] vd;
        logic [4:0] vs2;
    } opT;

    typedef struct {
        opT         op;
        int         expN;
        bit         expErr;
        logic [3:0] expLastBe;
        logic [4:0] expLastVd;
    } vecT;

    typedef struct {
        logic [4:0] vd;
        logic [4:0] vs2;
        logic [1:0] bytes;
        logic [3:0] be;
        logic       first;
        logic       last;
    } uopT;

    logic       clk_i;
    logic       async_rst_ni;
    logic       op_valid_i;
    logic       op_ready_o;
    logic [1:0] op_vsew_i;
    logic [1:0] op_emul_i;
    logic [1:0] op_evl_i;
    logic [7:0] op_vl_i;
    logic [4:0] op_vd_i;
    logic [4:0] op_vs2_i;
    logic       uop_valid_o;
    logic       uop_ready_i;
    logic [4:0] uop_vd_o;
    logic [4:0] uop_vs2_o;
    logic [1:0] uop_bytes_o;
    logic [3:0] uop_be_o;
    logic       uop_first_o;
    logic       uop_last_o;
    logic       err_o;
    logic       flush_i;

    int  nPass  = 0;
    int  nTotal = 0;
    uopT expQ[$];
    bit  expMis;

    vproc_uop_seq #(.VREG_W(128), .OP_W(32)) dut (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .op_valid_i   (op_valid_i),
        .op_ready_o   (op_ready_o),
        .op_vsew_i    (op_vsew_i),
        .op_emul_i    (op_emul_i),
        .op_evl_i     (op_evl_i),
        .op_vl_i      (op_vl_i),
        .op_vd_i      (op_vd_i),
        .op_vs2_i     (op_vs2_i),
        .uop_valid_o  (uop_valid_o),
        .uop_ready_i  (uop_ready_i),
        .uop_vd_o     (uop_vd_o),
        .uop_vs2_o    (uop_vs2_o),
        .uop_bytes_o  (uop_bytes_o),
        .uop_be_o     (uop_be_o),
        .uop_first_o  (uop_first_o),
        .uop_last_o   (uop_last_o),
        .err_o        (err_o),
        .flush_i      (flush_i)
    );

    // Free-running clock, rising edge at 5, 15, 25, ...
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Hard stop in case a sequence never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nTotal++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input opT op, input logic valid);
        op_valid_i = valid;
        op_vsew_i  = op.vsew;
        op_emul_i  = op.emul;
        op_evl_i   = op.evl;
        op_vl_i    = op.vl;
        op_vd_i    = op.vd;
        op_vs2_i   = op.vs2;
    endtask

    function automatic logic [18:0] packOut();
        return {uop_valid_o, uop_vd_o, uop_vs2_o, uop_bytes_o, uop_be_o, uop_first_o, uop_last_o};
    endfunction

    function automatic logic [18:0] packExp(input uopT u);
        return {1'b1, u.vd, u.vs2, u.bytes, u.be, u.first, u.last};
    endfunction

    function automatic opT mkOp(input int vsew, input int emul, input int evl,
                                input int vl, input int vd, input int vs2);
        opT o;
        o.vsew = 2'(vsew); o.emul = 2'(emul); o.evl = 2'(evl);
        o.vl = 8'(vl); o.vd = 5'(vd); o.vs2 = 5'(vs2);
        return o;
    endfunction

    // Reference model: expand an operation into the ordered list of
    // micro-ops it should produce, from byte counts and chunk arithmetic.
    task automatic modelOp(input opT op);
        int  tb;
        int  n;
        int  grp;
        int  vd;
        int  vs2;
        uopT u;
        expQ.delete();
        grp = 1 << op.emul;
        vd  = int'(op.vd);
        vs2 = int'(op.vs2);
        expMis = ((vd % grp) != 0) || ((vs2 % grp) != 0);
        case (op.evl)
            2'd0:    tb = int'(op.vl) * (1 << op.vsew);
            2'd1:    tb = 1 << op.vsew;
            2'd2:    tb = (int'(op.vl) + 7) / 8;
            default: tb = REG_B * grp;
        endcase
        if (!expMis) begin
            n = (tb + OPB - 1) / OPB;
            for (int c = 0; c < n; c++) begin
                u.vd    = 5'((vd + c / CHUNKS) % 32);
                u.vs2   = 5'((vs2 + c / CHUNKS) % 32);
                u.bytes = 2'(c % CHUNKS);
                for (int b = 0; b < OPB; b++) u.be[b] = (c * OPB + b < tb);
                u.first = (c == 0);
                u.last  = (c == n - 1);
                expQ.push_back(u);
            end
        end
    endtask

    // Runs one operation end to end and compares every presented micro-op
    // with the model. Stalls are random (stallPct) or forced at stallIdx;
    // flushIdx >= 0 raises flush together with the handshake of that uop.
    task automatic runOp(input opT op, input int stallPct, input int stallIdx,
                         input int stallLen, input int flushIdx,
                         output int nSeen, output bit errSeen,
                         output logic [3:0] lastBe, output logic [4:0] lastVd);
        bit flushed;
        int stall;
        modelOp(op);
        nSeen = 0; errSeen = 0; lastBe = '0; lastVd = '0; flushed = 0;
        @(negedge clk_i);
        uop_ready_i = 1'b0;
        applyStimulus(op, 1'b1);
        #1 checkOutput("op_ready_idle", 32'(op_ready_o), 32'd1);
        @(negedge clk_i);
        op_valid_i = 1'b0;
        #1;
        errSeen = err_o;
        if (expMis) begin
            checkOutput("err_pulse", 32'(err_o), 32'd1);
            checkOutput("no_uop_on_err", 32'(uop_valid_o), 32'd0);
            @(negedge clk_i);
            #1 checkOutput("err_one_cycle", 32'({err_o, op_ready_o}), 32'b01);
        end else if (expQ.size() == 0) begin
            checkOutput("empty_op", 32'({err_o, uop_valid_o, op_ready_o}), 32'b001);
        end else begin
            for (int k = 0; k < expQ.size(); k++) begin
                stall = (k == stallIdx) ? stallLen
                      : (($urandom_range(0, 99) < stallPct) ? $urandom_range(1, 3) : 0);
                for (int s = 0; s < stall; s++) begin
                    uop_ready_i = 1'b0;
                    #1 checkOutput($sformatf("uop%0d_stall%0d", k, s), 32'(packOut()), 32'(packExp(expQ[k])));
                    @(negedge clk_i);
                end
                uop_ready_i = 1'b1;
                if (k == flushIdx) begin
                    flush_i = 1'b1;
                    applyStimulus(op, 1'b1);
                end
                #1 checkOutput($sformatf("uop%0d", k), 32'(packOut()), 32'(packExp(expQ[k])));
                if (uop_valid_o) begin
                    nSeen++;
                    lastBe = uop_be_o;
                    lastVd = uop_vd_o;
                end
                @(negedge clk_i);
                if (k == flushIdx) begin
                    flush_i = 1'b0;
                    op_valid_i = 1'b0;
                    uop_ready_i = 1'b0;
                    #1 checkOutput("flush_idle", 32'({uop_valid_o, op_ready_o}), 32'b01);
                    @(negedge clk_i);
                    #1 checkOutput("flush_no_accept", 32'(uop_valid_o), 32'd0);
                    flushed = 1;
                    break;
                end
            end
            if (!flushed) begin
                uop_ready_i = 1'b0;
                #1 checkOutput("op_done_idle", 32'({uop_valid_o, op_ready_o, err_o}), 32'b010);
            end
        end
    endtask

    initial begin
        vecT        vecs[$];
        vecT        v;
        opT         op;
        int         nSeen;
        bit         errSeen;
        logic [3:0] lastBe;
        logic [4:0] lastVd;
        int         grp;

        async_rst_ni = 1'b0;
        op_valid_i = 1'b0; op_vsew_i = '0; op_emul_i = '0; op_evl_i = '0;
        op_vl_i = '0; op_vd_i = '0; op_vs2_i = '0;
        uop_ready_i = 1'b0; flush_i = 1'b0;

        #3;
        checkOutput("reset_ready", 32'(op_ready_o), 32'd1);
        checkOutput("reset_outputs", 32'({packOut(), err_o}), 32'd0);
        @(negedge clk_i);
        async_rst_ni = 1'b1;

        // {op(vsew,emul,evl,vl,vd,vs2), uops, err, last be, last vd}
        v.op = mkOp(2, 0, 0, 3, 4, 8);    v.expN = 3;  v.expErr = 0; v.expLastBe = 4'b1111; v.expLastVd = 5'd4;  vecs.push_back(v);
        v.op = mkOp(0, 1, 0, 18, 6, 2);   v.expN = 5;  v.expErr = 0; v.expLastBe = 4'b0011; v.expLastVd = 5'd7;  vecs.push_back(v);
        v.op = mkOp(0, 3, 3, 0, 8, 16);   v.expN = 32; v.expErr = 0; v.expLastBe = 4'b1111; v.expLastVd = 5'd15; vecs.push_back(v);
        v.op = mkOp(0, 0, 2, 17, 1, 3);   v.expN = 1;  v.expErr = 0; v.expLastBe = 4'b0111; v.expLastVd = 5'd1;  vecs.push_back(v);
        v.op = mkOp(0, 1, 0, 8, 3, 4);    v.expN = 0;  v.expErr = 1; v.expLastBe = 4'b0000; v.expLastVd = 5'd0;  vecs.push_back(v);
        v.op = mkOp(2, 2, 0, 8, 4, 6);    v.expN = 0;  v.expErr = 1; v.expLastBe = 4'b0000; v.expLastVd = 5'd0;  vecs.push_back(v);
        v.op = mkOp(1, 0, 0, 0, 5, 5);    v.expN = 0;  v.expErr = 0; v.expLastBe = 4'b0000; v.expLastVd = 5'd0;  vecs.push_back(v);
        v.op = mkOp(1, 0, 1, 9, 2, 9);    v.expN = 1;  v.expErr = 0; v.expLastBe = 4'b0011; v.expLastVd = 5'd2;  vecs.push_back(v);
        v.op = mkOp(2, 0, 0, 20, 30, 31); v.expN = 20; v.expErr = 0; v.expLastBe = 4'b1111; v.expLastVd = 5'd2;  vecs.push_back(v);
        v.op = mkOp(0, 0, 0, 5, 11, 0);   v.expN = 2;  v.expErr = 0; v.expLastBe = 4'b0001; v.expLastVd = 5'd11; vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            runOp(vecs[i].op, 0, -1, 0, -1, nSeen, errSeen, lastBe, lastVd);
            checkOutput($sformatf("vec%0d_count", i), 32'(nSeen), 32'(vecs[i].expN));
            checkOutput($sformatf("vec%0d_err", i), 32'(errSeen), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d_last_be", i), 32'(lastBe), 32'(vecs[i].expLastBe));
            checkOutput($sformatf("vec%0d_last_vd", i), 32'(lastVd), 32'(vecs[i].expLastVd));
        end

        // Five-cycle backpressure on uop 1 of a five-uop op.
        runOp(mkOp(0, 1, 0, 18, 6, 2), 0, 1, 5, -1, nSeen, errSeen, lastBe, lastVd);
        checkOutput("stall_count", 32'(nSeen), 32'd5);

        // Flush during uop 2 of an eight-uop op.
        runOp(mkOp(2, 1, 0, 8, 10, 12), 0, -1, 0, 2, nSeen, errSeen, lastBe, lastVd);
        checkOutput("flush_count", 32'(nSeen), 32'd3);

        // Flush while idle blocks an offered op.
        @(negedge clk_i);
        flush_i = 1'b1;
        applyStimulus(mkOp(2, 0, 0, 3, 4, 8), 1'b1);
        #1 checkOutput("flush_idle_ready", 32'(op_ready_o), 32'd0);
        @(negedge clk_i);
        flush_i = 1'b0;
        op_valid_i = 1'b0;
        #1 checkOutput("flush_idle_no_uop", 32'({uop_valid_o, op_ready_o}), 32'b01);

        // Asynchronous reset in the middle of a 32-uop op, then an op on the
        // very first edge after release.
        @(negedge clk_i);
        applyStimulus(mkOp(0, 3, 3, 0, 8, 16), 1'b1);
        @(negedge clk_i);
        op_valid_i = 1'b0;
        uop_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #2 async_rst_ni = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 32'({packOut(), err_o}), 32'd0);
        checkOutput("async_reset_ready", 32'(op_ready_o), 32'd1);
        @(negedge clk_i);
        async_rst_ni = 1'b1;
        op = mkOp(2, 0, 0, 3, 4, 8);
        applyStimulus(op, 1'b1);
        #1 checkOutput("post_reset_ready", 32'(op_ready_o), 32'd1);
        @(negedge clk_i);
        op_valid_i = 1'b0;
        modelOp(op);
        #1 checkOutput("post_reset_uop0", 32'(packOut()), 32'(packExp(expQ[0])));
        @(negedge clk_i);
        @(negedge clk_i);
        @(negedge clk_i);
        uop_ready_i = 1'b0;
        #1 checkOutput("post_reset_done", 32'({uop_valid_o, op_ready_o}), 32'b01);

        // Randomized operations with random backpressure.
        for (int i = 0; i < 40; i++) begin
            op.vsew = 2'($urandom_range(0, 2));
            op.emul = 2'($urandom_range(0, 3));
            op.evl  = 2'($urandom_range(0, 3));
            op.vl   = 8'($urandom_range(0, 64));
            grp     = 1 << op.emul;
            op.vd   = 5'($urandom_range(0, 31));
            op.vs2  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) begin
                op.vd  = 5'(int'(op.vd) & ~(grp - 1));
                op.vs2 = 5'(int'(op.vs2) & ~(grp - 1));
            end
            runOp(op, 30, -1, 0, -1, nSeen, errSeen, lastBe, lastVd);
            checkOutput($sformatf("rand%0d_count", i), 32'(nSeen), 32'(expQ.size()));
            checkOutput($sformatf("rand%0d_err", i), 32'(errSeen), 32'(expMis));
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/vproc_uop_seq.md
VPROC_UOP_SEQ -- requirements
Module: vproc_uop_seq

Interface
REQ-001 VREG_W, 128: vector register width in bits; power of two, at least 64.
REQ-002 OP_W, 32: datapath bits processed per micro-op; power of two, at least 8, at most VREG_W.
REQ-003 clk_i  in  1  sole clock; all state updates on the rising edge.
REQ-004 async_rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 op_valid_i / op_ready_o  in/out  1  operation handshake; transfer occurs when both are high on a clock edge.
REQ-006 op_vsew_i  in  2  element width, cfg_vsew encoding; VSEW_INVALID is not allowed.
REQ-007 op_emul_i  in  2  register group size, cfg_emul encoding (1/2/4/8 registers).
REQ-008 op_evl_i  in  2  effective-vector-length policy, evl_policy encoding.
REQ-009 op_vl_i  in  $clog2(VREG_W)+1  vector length in elements.
REQ-010 op_vd_i, op_vs2_i  in  5 each  base destination and source register addresses.
REQ-011 uop_valid_o / uop_ready_i  out/in  1  micro-op handshake.
REQ-012 uop_vd_o, uop_vs2_o  out  5 each  register addressed by the current micro-op.
REQ-013 uop_bytes_o  out  $clog2(VREG_W/OP_W)  chunk offset within the register.
REQ-014 uop_be_o  out  OP_W/8  per-byte active enable.
REQ-015 uop_first_o, uop_last_o  out  1 each  first and last micro-op of the operation.
REQ-016 err_o  out  1  one-cycle pulse for a rejected (misaligned) operation.
REQ-017 flush_i  in  1  aborts the operation in progress.

Function
REQ-018 The block SHALL implement two states, IDLE and RUN; op_ready_o SHALL be high only in IDLE.
REQ-019 On op transfer the block SHALL latch all op fields and compute total bytes TB: DEFAULT = vl<<vsew; EVL_1 = 1<<vsew; EVL_MASK = ceil(vl/8); EVL_MAX = (VREG_W/8)<<emul.
REQ-020 If op_vd_i or op_vs2_i is not a multiple of the group size 2^emul, the op SHALL be consumed, err_o SHALL pulse in the next cycle, no micro-op SHALL issue, and the state SHALL stay IDLE.
REQ-021 If TB=0, the op SHALL be consumed with no micro-op and no err_o.
REQ-022 Otherwise the state SHALL become RUN and uop_valid_o SHALL rise in the cycle after transfer (1-cycle latency).
REQ-023 Chunk index c SHALL start at 0 and advance by 1 on each uop handshake; there are C = VREG_W/OP_W chunks per register.
REQ-024 uop_vd_o = op_vd + c/C and uop_vs2_o = op_vs2 + c/C, truncated to 5 bits (wrap modulo 32); uop_bytes_o = c mod C.
REQ-025 uop_be_o bit b SHALL be 1 iff c*(OP_W/8)+b < TB.
REQ-026 uop_first_o SHALL be high iff c=0; uop_last_o SHALL be high iff (c+1)*(OP_W/8) >= TB.
REQ-027 A handshake with uop_last_o high SHALL return the state to IDLE; op_ready_o SHALL rise in the following cycle.
REQ-028 While uop_valid_o is high and uop_ready_i is low, all uop_* outputs SHALL hold stable.
REQ-029 flush_i SHALL take priority over every handshake: the state SHALL go to IDLE at the next edge, and any op offered in that cycle SHALL NOT be accepted.
REQ-030 err_o SHALL NOT assert in RUN.

Reset
REQ-031 On async_rst_ni low the block SHALL be in IDLE with uop_valid_o=0, err_o=0, op_ready_o=1, and all other outputs 0, including during an operation in progress.
REQ-032 After reset is released, the first op SHALL be acceptable on the first rising edge.

Verification (VREG_W=128, OP_W=32)
REQ-033 vsew=32, emul1, vl=3, DEFAULT, vd=4 -> 3 uops, vd 4, bytes 0,1,2, be 1111 on each, first on uop 0, last on uop 2.
REQ-034 vsew=8, emul2, vl=18, vd=6 -> 5 uops; uops 0-3 vd=6; uop 4 vd=7, bytes 0, be 0011, last.
REQ-035 EVL_MAX, emul8, vd=8 -> 32 uops, vd 8..15 each for 4 uops, all be 1111; EVL_MASK, vl=17 -> 1 uop, be 0111.
REQ-036 emul2, vd=3 -> no uop, err_o high for exactly 1 cycle, op_ready_o high the next cycle.
REQ-037 uop_ready_i low for 5 cycles mid-operation -> outputs stable; flush_i during uop 2 -> IDLE next cycle, no further uops.
REQ-038 async_rst_ni low mid-operation -> uop_valid_o=0 immediately, without waiting for a clock edge.
